// File: rtl/vcount_mod_if.sv
// vcount_mod_if: control and status bundle for one vcount_mod count channel.
`default_nettype none

interface vcount_mod_if #(
   parameter int WIDTH = 3
);
   logic             pause;
   logic             decrement;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             at_max;
   logic             at_min;

   modport master (
      output pause, decrement, load, load_val,
      input  q, tc, at_max, at_min
   );

   modport slave (
      input  pause, decrement, load, load_val,
      output q, tc, at_max, at_min
   );
endinterface

`default_nettype wire

// File: rtl/vcount_mod.sv
// vcount_mod: prescaled up/down modulo counter with wrap/saturate limits,
// synchronous clamped load and a one-cycle terminal-count pulse.
`default_nettype none

module vcount_mod #(
   parameter int WIDTH    = 3,
   parameter int MAX      = 2**WIDTH - 1,
   parameter int PRESCALE = 1,
   parameter bit SATURATE = 1'b0
) (
   input  wire              clk,
   input  wire              rst_n,
   vcount_mod_if.slave      bus
);
   localparam int               PCW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [WIDTH-1:0] C_MAX   = WIDTH'(MAX);
   localparam logic [PCW-1:0]   C_PCTOP = PCW'(PRESCALE - 1);

   logic [WIDTH-1:0] q_q, q_d;
   logic [PCW-1:0]   pc_q, pc_d;
   logic             tc_q, tc_d;
   logic             w_at_max, w_at_min;

   assign w_at_max = (q_q == C_MAX);
   assign w_at_min = (q_q == '0);

   always_comb begin
      q_d  = q_q;
      pc_d = pc_q;
      tc_d = 1'b0;
      if (bus.load) begin
         q_d  = (bus.load_val > C_MAX) ? C_MAX : bus.load_val;
         pc_d = '0;
      end else if (!bus.pause) begin
         if (pc_q == C_PCTOP) begin
            pc_d = '0;
            // tc flags any step attempted at a limit, including a saturated hold
            if (!bus.decrement) begin
               if (w_at_max) begin
                  tc_d = 1'b1;
                  q_d  = SATURATE ? q_q : '0;
               end else begin
                  q_d = q_q + WIDTH'(1);
               end
            end else begin
               if (w_at_min) begin
                  tc_d = 1'b1;
                  q_d  = SATURATE ? q_q : C_MAX;
               end else begin
                  q_d = q_q - WIDTH'(1);
               end
            end
         end else begin
            pc_d = pc_q + PCW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q  <= '0;
         pc_q <= '0;
         tc_q <= 1'b0;
      end else begin
         q_q  <= q_d;
         pc_q <= pc_d;
         tc_q <= tc_d;
      end
   end

   assign bus.q      = q_q;
   assign bus.tc     = tc_q;
   assign bus.at_max = w_at_max;
   assign bus.at_min = w_at_min;

endmodule

`default_nettype wire
